mem_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the 16x32 data memory (registered read, 1-cycle latency).

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer for a 16x32 data memory
// with a registered (1-cycle latency) read port.
//   clk, rst                     clock, asynchronous active-high reset
//   pN_req/we/addr/wdata (N=0,1) requester access (held until pN_gnt)
//   pN_gnt, pN_err               grant pulse, out-of-range flag (with grant)
//   pN_rvalid, rdata             read data return, one cycle after a read grant
//   mem_wr_addr/mem_rd_addr      memory addresses (hold last value when idle)
//   mem_reg_wr, mem_wr_din       memory write enable / data
//   mem_rd_dat                   memory read data (registered inside the memory)
// Grants, error flags, rvalid and the memory controls are combinational so a
// winner is served in the same cycle it is picked.
module mem_port_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic              p1_err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_reg_wr,
   output logic [DATA_W-1:0] mem_wr_din,
   input  logic [DATA_W-1:0] mem_rd_dat
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              rd_port_q, rd_port_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Winner selection and the winner's request fields
   logic              any_req;
   logic              win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_range;

   always_comb begin
      any_req = !rst && (p0_req || p1_req);
      if (FIXED_PRIO != 0)
         win = !p0_req;
      else if (p0_req && p1_req)
         win = rr_ptr_q;
      else
         win = !p0_req;
      sel_we    = win ? p1_we    : p0_we;
      sel_addr  = win ? p1_addr  : p0_addr;
      sel_wdata = win ? p1_wdata : p0_wdata;
      in_range  = sel_addr < ADDR_W'(DEPTH);
   end

   // State register plus held address/data/read-data registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= 1'b0;
         rd_port_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         rd_port_q <= rd_port_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next state and outputs
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      rd_port_d = rd_port_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rdata     = rdata_q;
      p0_gnt    = 1'b0;
      p1_gnt    = 1'b0;
      p0_err    = 1'b0;
      p1_err    = 1'b0;
      p0_rvalid = 1'b0;
      p1_rvalid = 1'b0;
      mem_reg_wr = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               p0_gnt  = !win;
               p1_gnt  = win;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               if (!in_range) begin
                  p0_err = !win;
                  p1_err = win;
               end else if (sel_we) begin
                  mem_reg_wr = 1'b1;
               end else begin
                  state_d   = RD_WAIT;
                  rd_port_d = win;
               end
               // The port not served now is preferred at the next contention
               if (FIXED_PRIO == 0)
                  rr_ptr_d = !win;
            end
         end
         RD_WAIT: begin
            rdata     = mem_rd_dat;
            rdata_d   = mem_rd_dat;
            p0_rvalid = !rd_port_q;
            p1_rvalid = rd_port_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      mem_wr_addr = addr_d;
      mem_rd_addr = addr_d;
      mem_wr_din  = wdata_d;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two arbiter instances (round-robin and fixed
// priority) from shared requesters, each with its own behavioural memory,
// and compares every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } op_t;

   logic        clk;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic [4:0]  addr  [2];
   logic [31:0] wdata [2];

   logic [1:0]  o_gnt [2];
   logic [1:0]  o_err [2];
   logic [1:0]  o_rv  [2];
   logic        o_wr  [2];
   logic [31:0] o_rdata [2];
   logic [4:0]  o_wra [2];
   logic [4:0]  o_rda [2];
   logic [31:0] o_din [2];
   logic [31:0] mrd   [2];

   logic        d0_p0_gnt, d0_p0_rv, d0_p0_err, d0_p1_gnt, d0_p1_rv, d0_p1_err;
   logic        d1_p0_gnt, d1_p0_rv, d1_p0_err, d1_p1_gnt, d1_p1_rv, d1_p1_err;

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];

   int total = 0;
   int bad   = 0;

   // Reference model state per DUT (0 = round robin, 1 = fixed priority)
   bit          busy      [2];
   bit          pend_port [2];
   logic [4:0]  pend_addr [2];
   bit          pref      [2];
   logic [31:0] ref_mem   [2][16];
   bit          g_any     [2];
   bit          g_win     [2];

   op_t q0[$];
   op_t q1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter #(.FIXED_PRIO(0)) dut0 (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
      .p0_gnt(d0_p0_gnt), .p0_rvalid(d0_p0_rv), .p0_err(d0_p0_err),
      .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
      .p1_gnt(d0_p1_gnt), .p1_rvalid(d0_p1_rv), .p1_err(d0_p1_err),
      .rdata(o_rdata[0]), .mem_wr_addr(o_wra[0]), .mem_rd_addr(o_rda[0]),
      .mem_reg_wr(o_wr[0]), .mem_wr_din(o_din[0]), .mem_rd_dat(mrd[0])
   );

   mem_port_arbiter #(.FIXED_PRIO(1)) dut1 (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
      .p0_gnt(d1_p0_gnt), .p0_rvalid(d1_p0_rv), .p0_err(d1_p0_err),
      .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
      .p1_gnt(d1_p1_gnt), .p1_rvalid(d1_p1_rv), .p1_err(d1_p1_err),
      .rdata(o_rdata[1]), .mem_wr_addr(o_wra[1]), .mem_rd_addr(o_rda[1]),
      .mem_reg_wr(o_wr[1]), .mem_wr_din(o_din[1]), .mem_rd_dat(mrd[1])
   );

   assign o_gnt[0] = {d0_p1_gnt, d0_p0_gnt};
   assign o_err[0] = {d0_p1_err, d0_p0_err};
   assign o_rv[0]  = {d0_p1_rv,  d0_p0_rv};
   assign o_gnt[1] = {d1_p1_gnt, d1_p0_gnt};
   assign o_err[1] = {d1_p1_err, d1_p0_err};
   assign o_rv[1]  = {d1_p1_rv,  d1_p0_rv};

   // Environment memories: synchronous write, registered read
   always @(posedge clk) begin
      if (o_wr[0]) mem_a[o_wra[0][3:0]] <= o_din[0];
      mrd[0] <= mem_a[o_rda[0][3:0]];
      if (o_wr[1]) mem_b[o_wra[1][3:0]] <= o_din[1];
      mrd[1] <= mem_b[o_rda[1][3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         busy[d]  = 1'b0;
         pref[d]  = 1'b0;
         g_any[d] = 1'b0;
         g_win[d] = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d gnt", tag, d), 32'(o_gnt[d]), 32'd0);
         chk($sformatf("%s d%0d err", tag, d), 32'(o_err[d]), 32'd0);
         chk($sformatf("%s d%0d rvalid", tag, d), 32'(o_rv[d]), 32'd0);
         chk($sformatf("%s d%0d reg_wr", tag, d), 32'(o_wr[d]), 32'd0);
         chk($sformatf("%s d%0d rdata", tag, d), o_rdata[d], 32'd0);
         chk($sformatf("%s d%0d addr", tag, d), 32'({o_wra[d], o_rda[d]}), 32'd0);
         chk($sformatf("%s d%0d din", tag, d), o_din[d], 32'd0);
      end
   endtask

   // One clock cycle: check both DUTs at the negedge, advance model at the posedge,
   // then let requesters react to the round-robin DUT's grants.
   task automatic step();
      logic [1:0] e_gnt, e_err, e_rv;
      logic       e_wr;
      bit         w;
      bit         oor;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         e_gnt = 2'b00; e_err = 2'b00; e_rv = 2'b00; e_wr = 1'b0;
         g_any[d] = 1'b0;
         if (busy[d]) begin
            e_rv[pend_port[d]] = 1'b1;
            chk($sformatf("d%0d rdata", d), o_rdata[d], ref_mem[d][pend_addr[d][3:0]]);
         end else if (req[0] || req[1]) begin
            if (d == 1 || !(req[0] && req[1])) w = !req[0];
            else w = pref[d];
            g_any[d] = 1'b1;
            g_win[d] = w;
            oor = addr[w] >= 5'd16;
            e_gnt[w] = 1'b1;
            e_err[w] = oor;
            e_wr = we[w] && !oor;
            chk($sformatf("d%0d wr_addr", d), 32'(o_wra[d]), 32'(addr[w]));
            chk($sformatf("d%0d rd_addr", d), 32'(o_rda[d]), 32'(addr[w]));
            chk($sformatf("d%0d wr_din", d), o_din[d], wdata[w]);
         end
         chk($sformatf("d%0d gnt", d), 32'(o_gnt[d]), 32'(e_gnt));
         chk($sformatf("d%0d err", d), 32'(o_err[d]), 32'(e_err));
         chk($sformatf("d%0d rvalid", d), 32'(o_rv[d]), 32'(e_rv));
         chk($sformatf("d%0d reg_wr", d), 32'(o_wr[d]), 32'(e_wr));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (busy[d]) begin
            busy[d] = 1'b0;
         end else if (g_any[d]) begin
            w = g_win[d];
            if (addr[w] < 5'd16) begin
               if (we[w]) ref_mem[d][addr[w][3:0]] = wdata[w];
               else begin
                  busy[d] = 1'b1;
                  pend_port[d] = w;
                  pend_addr[d] = addr[w];
               end
            end
            if (d == 0) pref[d] = !w;
         end
      end
      #1;
      if (g_any[0]) req[g_win[0]] = 1'b0;
      if (!req[0] && q0.size() > 0) begin
         op_t o = q0.pop_front();
         req[0] = 1'b1; we[0] = o.we; addr[0] = o.addr; wdata[0] = o.data;
      end
      if (!req[1] && q1.size() > 0) begin
         op_t o = q1.pop_front();
         req[1] = 1'b1; we[1] = o.we; addr[1] = o.addr; wdata[1] = o.data;
      end
   endtask

   task automatic run(input int maxc);
      int c = 0;
      while ((q0.size() > 0 || q1.size() > 0 || req[0] || req[1] || busy[0] || busy[1])
             && c < maxc) begin
         step();
         c++;
      end
      step();
      chk("drain_timeout", 32'(c < maxc), 32'd1);
   endtask

   task automatic push(input int p, input logic w, input logic [4:0] a, input logic [31:0] dt);
      op_t o;
      o.we = w; o.addr = a; o.data = dt;
      if (p == 0) q0.push_back(o);
      else q1.push_back(o);
   endtask

   initial begin
      int c;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0; mem_b[i] = '0;
         ref_mem[0][i] = '0; ref_mem[1][i] = '0;
      end
      for (int n = 0; n < 2; n++) begin
         req[n] = 1'b0; we[n] = 1'b0; addr[n] = '0; wdata[n] = '0;
      end
      model_reset();
      rst = 1'b1;
      #12;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Write then read back on port 0
      push(0, 1'b1, 5'd3, 32'hDEADBEEF);
      push(0, 1'b0, 5'd3, 32'h0);
      run(50);

      // Contending reads: alternation on dut0, starvation of p1 on dut1
      for (int i = 0; i < 6; i++) begin
         push(0, 1'b0, 5'd1, 32'h0);
         push(1, 1'b0, 5'd2, 32'h0);
      end
      run(100);

      // Out-of-range write on port 1 must leave address 0 intact
      push(1, 1'b1, 5'd0, 32'h12345678);
      push(1, 1'b1, 5'd16, 32'hBAD0BAD0);
      push(1, 1'b0, 5'd0, 32'h0);
      run(50);

      // Reset during the read-wait cycle of a p1 read
      push(1, 1'b0, 5'd3, 32'h0);
      c = 0;
      while (!(g_any[0] && g_win[0]) && c < 20) begin
         step();
         c++;
      end
      chk("rst_rd_grant_seen", 32'(c < 20), 32'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_in_rdwait");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      step();
      step();
      push(1, 1'b0, 5'd3, 32'h0);
      run(50);

      // Back-to-back writes over the whole array, then readback
      for (int i = 0; i < 16; i++) push(0, 1'b1, 5'(i), $urandom);
      run(100);
      for (int i = 0; i < 16; i++) push(0, 1'b0, 5'(i), 32'h0);
      run(100);

      // Random mixed traffic, including out-of-range addresses
      for (int i = 0; i < 60; i++) begin
         push(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom);
         push(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom);
      end
      run(2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
